axi_multi_ch_arb: RTL and testbench

AXI_MULTI_CH_ARB -- requirements
Module: axi_multi_ch_arb

---
 rtl/axi_ddr_pkg.sv | 19 +
 rtl/axi_multi_ch_arb_if.sv | 36 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/axi_multi_ch_arb.sv | 138 +++++++++++++
 tb/tb_axi_multi_ch_arb.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/axi_ddr_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axi_ddr_pkg : shared FSM encoding and beat-size helper for the arbiter |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package axi_ddr_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2
   } state_t;

   function automatic int bytes_per_beat(input int data_w);
      return data_w / 8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_multi_ch_arb_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axi_multi_ch_arb_if : channel request side and AXI master side bundle  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface axi_multi_ch_arb_if #(
   parameter int CH_NUM = 4,
   parameter int ADDR_W = 30,
   parameter int LEN_W  = 8
);
   logic [CH_NUM-1:0]        ch_req;
   logic [CH_NUM*ADDR_W-1:0] ch_beg_addr;
   logic [CH_NUM*ADDR_W-1:0] ch_end_addr;
   logic [CH_NUM*LEN_W-1:0]  ch_burst_len;
   logic [CH_NUM-1:0]        ch_addr_clr;
   logic [CH_NUM-1:0]        ch_grant;
   logic [CH_NUM-1:0]        ch_done;
   logic                     m_ready;
   logic                     m_start;
   logic [ADDR_W-1:0]        m_addr;
   logic [LEN_W-1:0]         m_len;
   logic                     m_done;

   modport slave (
      input  ch_req, ch_beg_addr, ch_end_addr, ch_burst_len, ch_addr_clr,
             m_ready, m_done,
      output ch_grant, ch_done, m_start, m_addr, m_len
   );

   modport master (
      output ch_req, ch_beg_addr, ch_end_addr, ch_burst_len, ch_addr_clr,
             m_ready, m_done,
      input  ch_grant, ch_done, m_start, m_addr, m_len
   );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin, search begins after last grant |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module rr_arbiter #(
   parameter int CH_NUM = 4
) (
   input  wire logic [CH_NUM-1:0] i_req,
   input  wire logic [CH_NUM-1:0] i_last_grant,
   output logic      [CH_NUM-1:0] o_grant
);
   logic [CH_NUM-1:0] w_mask;
   logic [CH_NUM-1:0] w_hi_req;
   logic [CH_NUM-1:0] w_hi_grant;
   logic [CH_NUM-1:0] w_lo_grant;

   // Mask keeps only channels strictly above the last winner; fall back to the full set on wrap.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         for (int j = 0; j < i; j++) begin
            if (i_last_grant[j]) w_mask[i] = 1'b1;
         end
      end
      w_hi_req   = i_req & w_mask;
      w_hi_grant = w_hi_req & (~w_hi_req + CH_NUM'(1));
      w_lo_grant = i_req & (~i_req + CH_NUM'(1));
      o_grant    = (|w_hi_req) ? w_hi_grant : w_lo_grant;
   end
endmodule
`default_nettype wire

// File: rtl/axi_multi_ch_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axi_multi_ch_arb : round-robin burst arbiter with per-channel pointers |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module axi_multi_ch_arb
   import axi_ddr_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int ADDR_W = 30,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 8
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   axi_multi_ch_arb_if.slave  bus
);
   localparam logic [ADDR_W:0]   c_bpb      = (ADDR_W+1)'(bytes_per_beat(DATA_W));
   localparam logic [CH_NUM-1:0] c_last_rst = {1'b1, {(CH_NUM-1){1'b0}}};

   state_t            r_state;
   logic [CH_NUM-1:0] r_grant;
   logic [CH_NUM-1:0] r_last;
   logic [CH_NUM-1:0] r_done;
   logic              r_start;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic [ADDR_W-1:0] r_ptr [CH_NUM];
   logic [CH_NUM-1:0] r_init;

   logic [CH_NUM-1:0] w_arb_grant;
   logic [ADDR_W-1:0] w_ptr [CH_NUM];
   logic [ADDR_W-1:0] w_sel_addr;
   logic [LEN_W-1:0]  w_sel_len;
   logic [ADDR_W-1:0] w_cur_ptr;
   logic [ADDR_W-1:0] w_cur_beg;
   logic [ADDR_W-1:0] w_cur_end;
   logic [ADDR_W:0]   w_beats;
   logic [ADDR_W:0]   w_sum;
   logic [ADDR_W-1:0] w_next_ptr;
   logic              w_burst_end;

   rr_arbiter #(.CH_NUM(CH_NUM)) u_rr (
      .i_req        (bus.ch_req),
      .i_last_grant (r_last),
      .o_grant      (w_arb_grant)
   );

   // Untouched pointers read as beg_addr until their first write.
   for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ptr
      assign w_ptr[gi] = r_init[gi] ? r_ptr[gi] : bus.ch_beg_addr[gi*ADDR_W +: ADDR_W];
   end

   always_comb begin
      w_sel_addr = '0;
      w_sel_len  = '0;
      w_cur_ptr  = '0;
      w_cur_beg  = '0;
      w_cur_end  = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (w_arb_grant[i]) begin
            w_sel_addr = w_ptr[i];
            w_sel_len  = bus.ch_burst_len[i*LEN_W +: LEN_W];
         end
         if (r_grant[i]) begin
            w_cur_ptr = w_ptr[i];
            w_cur_beg = bus.ch_beg_addr[i*ADDR_W +: ADDR_W];
            w_cur_end = bus.ch_end_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // One extra bit so a carry out of ADDR_W still compares as past the region end.
   assign w_beats     = {{(ADDR_W+1-LEN_W){1'b0}}, r_len} + (ADDR_W+1)'(1);
   assign w_sum       = {1'b0, w_cur_ptr} + w_beats * c_bpb;
   assign w_next_ptr  = (w_sum >= {1'b0, w_cur_end}) ? w_cur_beg : w_sum[ADDR_W-1:0];
   assign w_burst_end = (r_state == S_BUSY) && bus.m_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH_NUM; i++) r_ptr[i] <= '0;
         r_init <= '0;
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (bus.ch_addr_clr[i]) begin
               r_ptr[i]  <= bus.ch_beg_addr[i*ADDR_W +: ADDR_W];
               r_init[i] <= 1'b1;
            end else if (w_burst_end && r_grant[i]) begin
               r_ptr[i]  <= w_next_ptr;
               r_init[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_last  <= c_last_rst;
         r_done  <= '0;
         r_start <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
      end else begin
         r_done  <= '0;
         r_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.m_ready && (|bus.ch_req)) begin
                  r_grant <= w_arb_grant;
                  r_last  <= w_arb_grant;
                  r_addr  <= w_sel_addr;
                  r_len   <= w_sel_len;
                  r_start <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: r_state <= S_BUSY;
            S_BUSY: begin
               if (bus.m_done) begin
                  r_done  <= r_grant;
                  r_grant <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ch_grant = r_grant;
   assign bus.ch_done  = r_done;
   assign bus.m_start  = r_start;
   assign bus.m_addr   = r_addr;
   assign bus.m_len    = r_len;
endmodule
`default_nettype wire

// File: tb/tb_axi_multi_ch_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_axi_multi_ch_arb : directed vector bench for axi_multi_ch_arb       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_axi_multi_ch_arb;
   logic clk = 1'b0;
   logic rst_n;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   axi_multi_ch_arb_if #(.CH_NUM(4), .ADDR_W(30), .LEN_W(8)) bus ();

   axi_multi_ch_arb #(.CH_NUM(4), .ADDR_W(30), .DATA_W(64), .LEN_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  grant;
      logic [29:0] addr;
      logic [7:0]  len;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Called at a negedge with the FSM idle; returns at the negedge after ch_done.
   task automatic run_burst(input logic [3:0] req, input logic [3:0] eg,
                            input logic [29:0] ea, input logic [7:0] el);
      int n;
      bus.ch_req  = req;
      bus.m_ready = 1'b1;
      n = 0;
      while (bus.m_start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("start_seen",    bus.m_start, 1);
      check("start_latency", n, 1);
      check("grant",         bus.ch_grant, eg);
      check("addr",          bus.m_addr, ea);
      check("len",           bus.m_len, el);
      @(negedge clk);
      check("start_one_cycle", bus.m_start, 0);
      @(negedge clk);
      @(negedge clk);
      check("busy_grant_hold", bus.ch_grant, eg);
      check("busy_addr_hold",  bus.m_addr, ea);
      bus.m_done = 1'b1;
      @(negedge clk);
      bus.m_done = 1'b0;
      check("done_pulse",     bus.ch_done, eg);
      check("grant_released", bus.ch_grant, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n            = 1'b0;
      bus.ch_req       = '0;
      bus.ch_addr_clr  = '0;
      bus.m_ready      = 1'b0;
      bus.m_done       = 1'b0;
      bus.ch_beg_addr  = {30'h6000, 30'h4000, 30'h2000, 30'h0000};
      bus.ch_end_addr  = {30'h6010, 30'h4100, 30'h3000, 30'h1000};
      bus.ch_burst_len = {8'd0, 8'd7, 8'd3, 8'd15};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_grant", bus.ch_grant, 0);
      check("rst_done",  bus.ch_done, 0);
      check("rst_start", bus.m_start, 0);
      check("rst_addr",  bus.m_addr, 0);
      check("rst_len",   bus.m_len, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single channel walks its region in 0x80 steps and wraps after 32 bursts
      for (int k = 0; k <= 32; k++)
         run_burst(4'b0001, 4'b0001, (k < 32) ? 30'(k * 32'h80) : 30'h0, 8'd15);

      // Reset in the middle of a burst
      run_burst_start_only: begin
         int n;
         bus.ch_req  = 4'b0010;
         bus.m_ready = 1'b1;
         n = 0;
         while (bus.m_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("mid_rst_start", bus.m_start, 1);
         check("mid_rst_addr",  bus.m_addr, 30'h2000);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_grant", bus.ch_grant, 0);
      check("async_rst_done",  bus.ch_done, 0);
      check("async_rst_start", bus.m_start, 0);
      check("async_rst_addr",  bus.m_addr, 0);
      check("async_rst_len",   bus.m_len, 0);
      bus.ch_req = '0;
      bus.m_done = 1'b1;
      @(negedge clk);
      bus.m_done = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst_no_done", bus.ch_done, 0);
      end

      // Round-robin table; channel pointers start from beg_addr again
      vecs.push_back('{4'b1111, 4'b0001, 30'h0000, 8'd15});
      vecs.push_back('{4'b1111, 4'b0010, 30'h2000, 8'd3});
      vecs.push_back('{4'b1111, 4'b0100, 30'h4000, 8'd7});
      vecs.push_back('{4'b1111, 4'b1000, 30'h6000, 8'd0});
      vecs.push_back('{4'b1111, 4'b0001, 30'h0080, 8'd15});
      vecs.push_back('{4'b0101, 4'b0100, 30'h4040, 8'd7});
      vecs.push_back('{4'b0101, 4'b0001, 30'h0100, 8'd15});
      vecs.push_back('{4'b0101, 4'b0100, 30'h4080, 8'd7});
      vecs.push_back('{4'b0101, 4'b0001, 30'h0180, 8'd15});
      vecs.push_back('{4'b0101, 4'b0100, 30'h40C0, 8'd7});
      vecs.push_back('{4'b0101, 4'b0001, 30'h0200, 8'd15});
      vecs.push_back('{4'b0101, 4'b0100, 30'h4000, 8'd7});
      vecs.push_back('{4'b1000, 4'b1000, 30'h6008, 8'd0});
      vecs.push_back('{4'b1000, 4'b1000, 30'h6000, 8'd0});
      for (int v = 0; v < vecs.size(); v++)
         run_burst(vecs[v].req, vecs[v].grant, vecs[v].addr, vecs[v].len);

      // m_ready low blocks the grant; a stray m_done while idle is ignored
      bus.m_ready = 1'b0;
      bus.ch_req  = 4'b0010;
      for (int c = 0; c < 10; c++) begin
         bus.m_done = (c == 5);
         @(negedge clk);
         check("ready_low_no_start", bus.m_start, 0);
         check("ready_low_no_done",  bus.ch_done, 0);
      end
      bus.m_done  = 1'b0;
      bus.m_ready = 1'b1;
      @(negedge clk);
      check("ready_rise_start", bus.m_start, 1);
      check("ready_rise_grant", bus.ch_grant, 4'b0010);
      check("ready_rise_addr",  bus.m_addr, 30'h2020);
      bus.ch_req = '0;
      @(negedge clk);
      check("req_drop_start_low", bus.m_start, 0);
      @(negedge clk);
      check("req_drop_grant_held", bus.ch_grant, 4'b0010);

      // Clear coincident with m_done of the same channel
      bus.m_done      = 1'b1;
      bus.ch_addr_clr = 4'b0010;
      @(negedge clk);
      bus.m_done      = 1'b0;
      bus.ch_addr_clr = '0;
      check("clr_done_pulse",   bus.ch_done, 4'b0010);
      check("clr_grant_zero",   bus.ch_grant, 0);
      check("clr_inflight_addr", bus.m_addr, 30'h2020);
      run_burst(4'b0010, 4'b0010, 30'h2000, 8'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
